control_unit: RTL and testbench

Hardwired sequencer that sits directly upstream of `system` and drives every one of its control inputs. It performs a two-cycle instruction fetch into the IR, decodes the instruction fields returned on `ir_msbs`, and issues one or two execute cycles per instruction. It then loops back to fetch. It is a Moore FSM plus a combinational control-word decoder.

---
 rtl/cu_pkg.sv | 93 +++++++++
 rtl/cu_decoder.sv | 86 ++++++++
 rtl/control_unit.sv | 92 +++++++++
 tb/tb_control_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the hardwired control unit.
// Control-word layout, state enum, opcode/funsel/select codes.
package cu_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_INIT,
    S_FETCH_L,
    S_FETCH_H,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_LDM = 4'h5;
  localparam logic [3:0] OP_STM = 4'h6;
  localparam logic [3:0] OP_BRA = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_DEC  = 2'b10;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_AR = 2'b01;
  localparam logic [1:0] ARF_SP = 2'b10;

  localparam logic [3:0] EN_PC  = 4'b0001;
  localparam logic [3:0] EN_AR  = 4'b0010;
  localparam logic [3:0] EN_SP  = 4'b0100;
  localparam logic [3:0] EN_ALL = 4'b1111;

  localparam logic [1:0] MUXA_IR  = 2'b01;
  localparam logic [1:0] MUXA_MEM = 2'b10;
  localparam logic [1:0] MUXA_ALU = 2'b11;
  localparam logic [1:0] MUXB_IR  = 2'b01;
  localparam logic       MUXC_RF  = 1'b1;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  typedef struct packed {
    logic       halted;
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_ir;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_rf;
    logic [3:0] regsel_arf;
    logic [3:0] rf_tsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic       wr_mem;
    logic       cs_mem;
    logic       ir_enable;
    logic       ir_lh;
    logic [1:0] muxsel_a;
    logic [1:0] muxsel_b;
    logic       muxsel_c;
  } ctrl_t;

  function automatic logic [3:0] onehot(input logic [1:0] r);
    onehot = 4'b0001 << r;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    unique case (1'b1)
      (op == OP_ADD): alu_code = ALU_ADD;
      (op == OP_SUB): alu_code = ALU_SUB;
      default:        alu_code = ALU_AND;
    endcase
  endfunction

  function automatic logic two_cycle(input logic [3:0] op);
    two_cycle = (op == OP_LDM) || (op == OP_STM);
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational control-word decoder.
// Maps (state, op, rd, rs) to every datapath control.
module cu_decoder
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic [1:0] rd,
  input  logic [1:0] rs,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_INIT: begin
        ctrl.regsel_arf = EN_ALL;
        ctrl.funsel_arf = FUN_CLR;
        ctrl.regsel_rf  = EN_ALL;
        ctrl.rf_tsel    = EN_ALL;
        ctrl.funsel_rf  = FUN_CLR;
        ctrl.ir_enable  = 1'b1;
        ctrl.funsel_ir  = FUN_CLR;
      end
      S_FETCH_L, S_FETCH_H: begin
        ctrl.cs_mem     = 1'b1;
        ctrl.outbsel    = ARF_PC;
        ctrl.ir_enable  = 1'b1;
        ctrl.funsel_ir  = FUN_LOAD;
        ctrl.ir_lh      = (state == S_FETCH_H);
        ctrl.regsel_arf = EN_PC;
        ctrl.funsel_arf = FUN_INC;
      end
      S_EXEC1: begin
        unique case (1'b1)
          (op == OP_LDI): begin
            ctrl.muxsel_a  = MUXA_IR;
            ctrl.funsel_rf = FUN_LOAD;
            ctrl.regsel_rf = onehot(rd);
          end
          is_alu(op): begin
            ctrl.rf_o1sel   = {1'b0, rd};
            ctrl.rf_o2sel   = {1'b0, rs};
            ctrl.muxsel_c   = MUXC_RF;
            ctrl.funsel_alu = alu_code(op);
            ctrl.muxsel_a   = MUXA_ALU;
            ctrl.funsel_rf  = FUN_LOAD;
            ctrl.regsel_rf  = onehot(rd);
          end
          (op == OP_INC): begin
            ctrl.funsel_rf = FUN_INC;
            ctrl.regsel_rf = onehot(rd);
          end
          two_cycle(op): begin
            ctrl.muxsel_b   = MUXB_IR;
            ctrl.funsel_arf = FUN_LOAD;
            ctrl.regsel_arf = EN_AR;
          end
          (op == OP_BRA): begin
            ctrl.muxsel_b   = MUXB_IR;
            ctrl.funsel_arf = FUN_LOAD;
            ctrl.regsel_arf = EN_PC;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        ctrl.cs_mem  = 1'b1;
        ctrl.outbsel = ARF_AR;
        if (op == OP_STM) begin
          ctrl.wr_mem     = 1'b1;
          ctrl.rf_o1sel   = {1'b0, rd};
          ctrl.muxsel_c   = MUXC_RF;
          ctrl.funsel_alu = ALU_PASSA;
        end else begin
          ctrl.muxsel_a  = MUXA_MEM;
          ctrl.funsel_rf = FUN_LOAD;
          ctrl.regsel_rf = onehot(rd);
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the system datapath.
// Holds the state register; the control word comes from cu_decoder.
module control_unit
  import cu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_msbs,
  output logic       halted,
  output logic [1:0] outasel,
  output logic [1:0] outbsel,
  output logic [1:0] funsel_ir,
  output logic [1:0] funsel_arf,
  output logic [1:0] funsel_rf,
  output logic [3:0] funsel_alu,
  output logic [3:0] regsel_rf,
  output logic [3:0] regsel_arf,
  output logic [3:0] rf_tsel,
  output logic [2:0] rf_o1sel,
  output logic [2:0] rf_o2sel,
  output logic       wr_mem,
  output logic       cs_mem,
  output logic       ir_enable,
  output logic       ir_lh,
  output logic [1:0] muxsel_a,
  output logic [1:0] muxsel_b,
  output logic       muxsel_c
);

  state_t     state;
  ctrl_t      ctrl;
  logic [3:0] op;

  assign op = ir_msbs[7:4];

  // S_RST is the idle-word state held until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:     state <= S_INIT;
        S_INIT:    state <= S_FETCH_L;
        S_FETCH_L: state <= S_FETCH_H;
        S_FETCH_H: state <= S_DECODE;
        S_DECODE:  state <= S_EXEC1;
        S_EXEC1: begin
          if (op == OP_HLT)
            state <= S_HALT;
          else if (two_cycle(op))
            state <= S_EXEC2;
          else
            state <= S_FETCH_L;
        end
        S_EXEC2:   state <= S_FETCH_L;
        S_HALT:    state <= S_HALT;
        default:   state <= S_RST;
      endcase
    end
  end

  cu_decoder u_dec (
    .state (state),
    .op    (op),
    .rd    (ir_msbs[3:2]),
    .rs    (ir_msbs[1:0]),
    .ctrl  (ctrl)
  );

  assign halted     = ctrl.halted;
  assign outasel    = ctrl.outasel;
  assign outbsel    = ctrl.outbsel;
  assign funsel_ir  = ctrl.funsel_ir;
  assign funsel_arf = ctrl.funsel_arf;
  assign funsel_rf  = ctrl.funsel_rf;
  assign funsel_alu = ctrl.funsel_alu;
  assign regsel_rf  = ctrl.regsel_rf;
  assign regsel_arf = ctrl.regsel_arf;
  assign rf_tsel    = ctrl.rf_tsel;
  assign rf_o1sel   = ctrl.rf_o1sel;
  assign rf_o2sel   = ctrl.rf_o2sel;
  assign wr_mem     = ctrl.wr_mem;
  assign cs_mem     = ctrl.cs_mem;
  assign ir_enable  = ctrl.ir_enable;
  assign ir_lh      = ctrl.ir_lh;
  assign muxsel_a   = ctrl.muxsel_a;
  assign muxsel_b   = ctrl.muxsel_b;
  assign muxsel_c   = ctrl.muxsel_c;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: instruction-level model pushes
// the expected control word of every cycle; a monitor compares.
module tb_control_unit;
  import cu_pkg::MUXA_IR;
  import cu_pkg::MUXA_MEM;
  import cu_pkg::MUXA_ALU;
  import cu_pkg::MUXB_IR;
  import cu_pkg::MUXC_RF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir_msbs = 8'h00;
  logic       halted;
  logic [1:0] outasel, outbsel, funsel_ir, funsel_arf, funsel_rf;
  logic [3:0] funsel_alu, regsel_rf, regsel_arf, rf_tsel;
  logic [2:0] rf_o1sel, rf_o2sel;
  logic       wr_mem, cs_mem, ir_enable, ir_lh;
  logic [1:0] muxsel_a, muxsel_b;
  logic       muxsel_c;

  always #5 clk = ~clk;

  control_unit #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .ir_msbs(ir_msbs), .halted(halted),
    .outasel(outasel), .outbsel(outbsel), .funsel_ir(funsel_ir),
    .funsel_arf(funsel_arf), .funsel_rf(funsel_rf),
    .funsel_alu(funsel_alu), .regsel_rf(regsel_rf),
    .regsel_arf(regsel_arf), .rf_tsel(rf_tsel), .rf_o1sel(rf_o1sel),
    .rf_o2sel(rf_o2sel), .wr_mem(wr_mem), .cs_mem(cs_mem),
    .ir_enable(ir_enable), .ir_lh(ir_lh), .muxsel_a(muxsel_a),
    .muxsel_b(muxsel_b), .muxsel_c(muxsel_c)
  );

  typedef struct packed {
    logic       halted;
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_ir;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_rf;
    logic [3:0] regsel_arf;
    logic [3:0] rf_tsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic       wr_mem;
    logic       cs_mem;
    logic       ir_enable;
    logic       ir_lh;
    logic [1:0] muxsel_a;
    logic [1:0] muxsel_b;
    logic       muxsel_c;
  } tw_t;

  typedef struct {
    tw_t   w;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic tw_t idle_w();
    tw_t w;
    w = '0;
    return w;
  endfunction

  function automatic tw_t init_w();
    tw_t w = '0;
    w.regsel_arf = 4'b1111;
    w.regsel_rf  = 4'b1111;
    w.rf_tsel    = 4'b1111;
    w.ir_enable  = 1'b1;
    return w;
  endfunction

  function automatic tw_t fetch_w(input logic lh);
    tw_t w = '0;
    w.cs_mem     = 1'b1;
    w.ir_enable  = 1'b1;
    w.funsel_ir  = 2'b01;
    w.ir_lh      = lh;
    w.regsel_arf = 4'b0001;
    w.funsel_arf = 2'b11;
    return w;
  endfunction

  function automatic tw_t halt_w();
    tw_t w = '0;
    w.halted = 1'b1;
    return w;
  endfunction

  // Instruction semantics -> list of execute-cycle control words.
  function automatic void exec_words(input logic [7:0] ins,
                                     output tw_t e1, output tw_t e2,
                                     output int n);
    logic [3:0] op;
    logic [1:0] rd, rs;
    op = ins[7:4];
    rd = ins[3:2];
    rs = ins[1:0];
    e1 = '0;
    e2 = '0;
    n  = 1;
    case (op)
      4'h0: begin
        e1.muxsel_a  = MUXA_IR;
        e1.funsel_rf = 2'b01;
        e1.regsel_rf = 4'(1 << rd);
      end
      4'h1, 4'h2, 4'h3: begin
        e1.rf_o1sel   = 3'(rd);
        e1.rf_o2sel   = 3'(rs);
        e1.muxsel_c   = MUXC_RF;
        e1.funsel_alu = (op == 4'h1) ? 4'b0100 :
                        (op == 4'h2) ? 4'b0110 : 4'b0111;
        e1.muxsel_a   = MUXA_ALU;
        e1.funsel_rf  = 2'b01;
        e1.regsel_rf  = 4'(1 << rd);
      end
      4'h4: begin
        e1.funsel_rf = 2'b11;
        e1.regsel_rf = 4'(1 << rd);
      end
      4'h5, 4'h6: begin
        n = 2;
        e1.muxsel_b   = MUXB_IR;
        e1.funsel_arf = 2'b01;
        e1.regsel_arf = 4'b0010;
        e2.cs_mem     = 1'b1;
        e2.outbsel    = 2'b01;
        if (op == 4'h5) begin
          e2.muxsel_a  = MUXA_MEM;
          e2.funsel_rf = 2'b01;
          e2.regsel_rf = 4'(1 << rd);
        end else begin
          e2.wr_mem     = 1'b1;
          e2.rf_o1sel   = 3'(rd);
          e2.muxsel_c   = MUXC_RF;
          e2.funsel_alu = 4'b0000;
        end
      end
      4'h7: begin
        e1.muxsel_b   = MUXB_IR;
        e1.funsel_arf = 2'b01;
        e1.regsel_arf = 4'b0001;
      end
      default: ;
    endcase
  endfunction

  task automatic step(input tw_t w, input logic [7:0] ir,
                      input string tag);
    @(posedge clk);
    #1;
    ir_msbs = ir;
    sbq.push_back('{w: w, tag: tag});
  endtask

  function automatic logic [7:0] junk();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic run_instr(input logic [7:0] ins);
    tw_t e1, e2;
    int  n;
    string t;
    exec_words(ins, e1, e2, n);
    t = $sformatf("%02h", ins);
    step(fetch_w(1'b0), junk(), {"fetch_l_", t});
    step(fetch_w(1'b1), junk(), {"fetch_h_", t});
    step(idle_w(), ins, {"decode_", t});
    step(e1, ins, {"exec1_", t});
    if (n == 2) step(e2, ins, {"exec2_", t});
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.push_back('{w: idle_w(), tag: "rst_release"});
    step(init_w(), junk(), "init");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.push_back('{w: idle_w(), tag: "rst"});
    step(idle_w(), junk(), "rst_hold");
    release_rst();
  endtask

  initial begin : monitor
    exp_t e;
    tw_t  got;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e   = sbq.pop_front();
        got = '{halted, outasel, outbsel, funsel_ir, funsel_arf,
                funsel_rf, funsel_alu, regsel_rf, regsel_arf, rf_tsel,
                rf_o1sel, rf_o2sel, wr_mem, cs_mem, ir_enable, ir_lh,
                muxsel_a, muxsel_b, muxsel_c};
        n_cmp++;
        if (got !== e.w) begin
          n_bad++;
          $display("FAIL %s: got %011h expected %011h",
                   e.tag, got, e.w);
        end
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    do_reset();
    run_instr(8'h04);
    run_instr(8'h2E);
    run_instr(8'h60);
    run_instr(8'h9B);
    run_instr(8'h5D);
    // Reset lands mid-fetch: outputs must go idle before the next edge.
    step(fetch_w(1'b0), junk(), "fetch_l_abort");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbq.push_back('{w: idle_w(), tag: "async_rst_fetch_h"});
    step(idle_w(), junk(), "rst_hold2");
    release_rst();
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom_range(0, 15))});
    end
    run_instr(8'h70);
    run_instr(8'hF0);
    for (int i = 0; i < 20; i++) step(halt_w(), junk(), "halt_hold");
    do_reset();
    for (int i = 0; i < 10; i++)
      run_instr({4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))});
    wait_cyc = 0;
    while (sbq.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
